// File: rtl/hmc_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hmc_fifo_pkg
// Description : Shared sizing helpers, default data width and write-side FSM
//               encoding for the HMC FIFO controllers.
// Revision    : 1.0 - initial release
// ============================================================================
package hmc_fifo_pkg;

    localparam int c_ffdata_w = 512;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } wr_state_e;

    // Number of bits needed to index 'value' distinct items (ceil(log2(value))).
    function automatic int clogb2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) begin
            res = res + 1;
        end
        return res;
    endfunction

    function automatic int maxof2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hmc_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : hmc_skid_buf
// Description : DEPTH-entry ring buffer (distributed RAM) with push/pop,
//               wrapping read/write pointers and an occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module hmc_skid_buf
    import hmc_fifo_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = clogb2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    localparam int                 c_ptr_w    = maxof2(1, clogb2(DEPTH));
    localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(DEPTH - 1);
    localparam logic [CNT_W-1:0]   c_full_cnt = CNT_W'(DEPTH);

    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [c_ptr_w-1:0] wptr_q, wptr_d;
    logic [c_ptr_w-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    // Explicit wrap keeps non-power-of-2 depths legal.
    function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
        return (p == c_last_ptr) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wptr_d  = push ? ptr_inc(wptr_q) : wptr_q;
        rptr_d  = pop  ? ptr_inc(rptr_q) : rptr_q;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rptr_q];
    assign count   = count_q;
    assign full    = (count_q == c_full_cnt);
    assign empty   = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/hmc_fifo_wr_credit_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hmc_fifo_wr_credit_ctrl
// Description : Credit-based write controller feeding the shared HMC data
//               FIFO through a local skid buffer, with a drain handshake.
// Optional    : HMC_WR_CRD_CHECK_EN adds the sticky crd_err output and a
//               write-without-credit assertion.
// Revision    : 1.0 - initial release
// ============================================================================
module hmc_fifo_wr_credit_ctrl
    import hmc_fifo_pkg::*;
#(
    parameter int FFDATA_W   = c_ffdata_w,
    parameter int FIFO_DEPTH = 512,
    parameter int SKID_NUM   = 2,
    parameter int CRD_W      = clogb2(FIFO_DEPTH + 1),
    parameter int BUF_W      = clogb2(SKID_NUM + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_vld,
    input  logic [FFDATA_W-1:0] in_data,
    output logic                in_rdy,
    output logic                fifo_wr_en,
    output logic [FFDATA_W-1:0] fifo_wr_data,
    input  logic                fifo_rd_pop,
    input  logic                drain_req,
    output logic                drain_done,
    output logic [CRD_W-1:0]    crd_cnt,
`ifdef HMC_WR_CRD_CHECK_EN
    output logic                crd_err,
`endif
    output logic [BUF_W-1:0]    buf_cnt
);

    localparam logic [CRD_W-1:0] c_crd_max = CRD_W'(FIFO_DEPTH);

    wr_state_e           state_q, state_d;
    logic                fifo_wr_en_q, fifo_wr_en_d;
    logic [FFDATA_W-1:0] fifo_wr_data_q, fifo_wr_data_d;
    logic                drain_done_q, drain_done_d;
    logic [CRD_W-1:0]    crd_cnt_q, crd_cnt_d;

    logic                w_push;
    logic                w_pop;
    logic                w_ret_ok;
    logic                w_buf_full;
    logic                w_buf_empty;
    logic [FFDATA_W-1:0] w_buf_rd_data;

    hmc_skid_buf #(
        .DATA_W (FFDATA_W),
        .DEPTH  (SKID_NUM),
        .CNT_W  (BUF_W)
    ) u_skid_buf (
        .clk     (clk),
        .rst     (rst),
        .push    (w_push),
        .pop     (w_pop),
        .wr_data (in_data),
        .rd_data (w_buf_rd_data),
        .count   (buf_cnt),
        .full    (w_buf_full),
        .empty   (w_buf_empty)
    );

    assign in_rdy   = (state_q == RUN) & ~w_buf_full;
    assign w_push   = in_vld & in_rdy;
    // Only registered credits gate the pop; a return this cycle helps next cycle.
    assign w_pop    = ~w_buf_empty & (crd_cnt_q != '0);
    assign w_ret_ok = fifo_rd_pop & (crd_cnt_q != c_crd_max);

    always_comb begin
        fifo_wr_en_d   = w_pop;
        fifo_wr_data_d = w_pop ? w_buf_rd_data : fifo_wr_data_q;

        crd_cnt_d = crd_cnt_q;
        if (w_pop && !w_ret_ok) begin
            crd_cnt_d = crd_cnt_q - 1'b1;
        end else if (!w_pop && w_ret_ok) begin
            crd_cnt_d = crd_cnt_q + 1'b1;
        end
    end

    // Leave DRAIN only once the final word has left the output register.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (drain_req) state_d = DRAIN;
            DRAIN:   if (w_buf_empty && !fifo_wr_en_q) state_d = DONE;
            DONE:    state_d = RUN;
            default: state_d = RUN;
        endcase
        drain_done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= RUN;
            fifo_wr_en_q   <= 1'b0;
            fifo_wr_data_q <= '0;
            drain_done_q   <= 1'b0;
            crd_cnt_q      <= c_crd_max;
        end else begin
            state_q        <= state_d;
            fifo_wr_en_q   <= fifo_wr_en_d;
            fifo_wr_data_q <= fifo_wr_data_d;
            drain_done_q   <= drain_done_d;
            crd_cnt_q      <= crd_cnt_d;
        end
    end

    assign fifo_wr_en   = fifo_wr_en_q;
    assign fifo_wr_data = fifo_wr_data_q;
    assign drain_done   = drain_done_q;
    assign crd_cnt      = crd_cnt_q;

`ifdef HMC_WR_CRD_CHECK_EN
    localparam logic c_param_bad = (FIFO_DEPTH < 1) || (SKID_NUM < 2);

    logic crd_err_q, crd_err_d;

    always_comb begin
        crd_err_d = crd_err_q | c_param_bad | (fifo_rd_pop & (crd_cnt_q == c_crd_max));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crd_err_q <= 1'b0;
        end else begin
            crd_err_q <= crd_err_d;
        end
    end

    assign crd_err = crd_err_q;

`ifndef SYNTHESIS
    a_wr_needs_credit: assert property (
        @(posedge clk) disable iff (rst)
        $rose(fifo_wr_en_q) |-> ($past(crd_cnt_q) != '0)
    );
`endif
`endif

endmodule
`default_nettype wire

// File: tb/tb_hmc_fifo_wr_credit_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hmc_fifo_wr_credit_ctrl
// Description : Self-checking bench; instance A uses FIFO_DEPTH=16, instance
//               B uses FIFO_DEPTH=4, both driven from the same inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hmc_fifo_wr_credit_ctrl;

    localparam int DW = 32;
    localparam int DA = 16;
    localparam int DB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_vld = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          fifo_rd_pop = 1'b0;
    logic          drain_req = 1'b0;

    logic          a_in_rdy, a_wr_en, a_done;
    logic [DW-1:0] a_wr_data;
    logic [4:0]    a_crd;
    logic [1:0]    a_buf;
    logic          b_in_rdy, b_wr_en, b_done;
    logic [DW-1:0] b_wr_data;
    logic [2:0]    b_crd;
    logic [1:0]    b_buf;
`ifdef HMC_WR_CRD_CHECK_EN
    logic          a_err, b_err;
`endif

    always #5 clk = ~clk;

    hmc_fifo_wr_credit_ctrl #(.FFDATA_W(DW), .FIFO_DEPTH(DA), .SKID_NUM(2)) u_dut_a (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_data(in_data), .in_rdy(a_in_rdy),
        .fifo_wr_en(a_wr_en), .fifo_wr_data(a_wr_data), .fifo_rd_pop(fifo_rd_pop),
        .drain_req(drain_req), .drain_done(a_done), .crd_cnt(a_crd),
`ifdef HMC_WR_CRD_CHECK_EN
        .crd_err(a_err),
`endif
        .buf_cnt(a_buf)
    );

    hmc_fifo_wr_credit_ctrl #(.FFDATA_W(DW), .FIFO_DEPTH(DB), .SKID_NUM(2)) u_dut_b (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_data(in_data), .in_rdy(b_in_rdy),
        .fifo_wr_en(b_wr_en), .fifo_wr_data(b_wr_data), .fifo_rd_pop(fifo_rd_pop),
        .drain_req(drain_req), .drain_done(b_done), .crd_cnt(b_crd),
`ifdef HMC_WR_CRD_CHECK_EN
        .crd_err(b_err),
`endif
        .buf_cnt(b_buf)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic          rst;
        logic          vld;
        logic [DW-1:0] data;
        logic          rdy;
        logic          en;
        logic [DW-1:0] wdata;
        int            crd;
        int            bcnt;
    } vec_t;

    function automatic vec_t mkv(logic r, logic v, logic [DW-1:0] d, logic rdy,
                                 logic en, logic [DW-1:0] wd, int crd, int bc);
        vec_t x;
        x.rst = r; x.vld = v; x.data = d; x.rdy = rdy;
        x.en = en; x.wdata = wd; x.crd = crd; x.bcnt = bc;
        return x;
    endfunction

    // Streams words into the shared inputs until B has accepted 6 of them.
    task automatic fill_b(input logic [DW-1:0] base, output int acc, output int wr);
        logic took;
        acc = 0;
        wr  = 0;
        for (int c = 0; c < 20 && acc < 6; c++) begin
            in_vld  = 1'b1;
            in_data = base + DW'(acc);
            took    = b_in_rdy;
            step();
            if (took) acc++;
            if (b_wr_en) wr++;
        end
        in_vld = 1'b0;
    endtask

    vec_t vt[11];
    int   acc, wr_cnt, dn_cnt, rdy_seen;
    logic prev_done;

    logic [DW-1:0] mq[$];
    int            m_crd, m_mode, m_nmode, m_occ, ret_pct;
    logic          m_en, m_rdy, m_push, m_pop, m_ret;
    logic [DW-1:0] m_data;

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- Test 1: table-driven back-to-back stream on A
        vt[0] = mkv(1'b1, 1'b0, '0, 1'b1, 1'b0, '0, DA, 0);
        for (int k = 1; k <= 8; k++) begin
            vt[k] = mkv(1'b0, 1'b1, DW'(k), 1'b1, (k >= 2), (k >= 2) ? DW'(k - 1) : '0, DA - (k - 1), 1);
        end
        vt[9]  = mkv(1'b0, 1'b0, '0, 1'b1, 1'b1, DW'(8), 8, 0);
        vt[10] = mkv(1'b0, 1'b0, '0, 1'b1, 1'b0, DW'(8), 8, 0);

        for (int i = 0; i < 11; i++) begin
            rst     = vt[i].rst;
            in_vld  = vt[i].vld;
            in_data = vt[i].data;
            step();
            chk($sformatf("t1_rdy[%0d]", i),   a_in_rdy,  vt[i].rdy);
            chk($sformatf("t1_en[%0d]", i),    a_wr_en,   vt[i].en);
            chk($sformatf("t1_data[%0d]", i),  a_wr_data, vt[i].wdata);
            chk($sformatf("t1_crd[%0d]", i),   a_crd,     vt[i].crd);
            chk($sformatf("t1_buf[%0d]", i),   a_buf,     vt[i].bcnt);
        end

        // ---------------- Test 2: credit exhaustion on B (depth 4)
        rst = 1'b1; step(); rst = 1'b0;
        fill_b(DW'(1), acc, wr_cnt);
        for (int c = 0; c < 6; c++) begin
            step();
            if (b_wr_en) wr_cnt++;
        end
        chk("t2_accepted", acc, 6);
        chk("t2_writes", wr_cnt, 4);
        chk("t2_last_data", b_wr_data, 4);
        chk("t2_crd", b_crd, 0);
        chk("t2_buf", b_buf, 2);
        chk("t2_rdy", b_in_rdy, 0);
        fifo_rd_pop = 1'b1; step(); fifo_rd_pop = 1'b0;
        chk("t2_no_bypass_en", b_wr_en, 0);
        chk("t2_crd_ret", b_crd, 1);
        step();
        chk("t2_ret_write_en", b_wr_en, 1);
        chk("t2_ret_write_data", b_wr_data, 5);
        wr_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (b_wr_en) wr_cnt++;
        end
        chk("t2_no_more_writes", wr_cnt, 0);
        chk("t2_crd_end", b_crd, 0);
        chk("t2_buf_end", b_buf, 1);

        // ---------------- Test 3: simultaneous pop and return at crd=1
        in_vld = 1'b1; fifo_rd_pop = 1'b1;
        for (int c = 0; c < 12; c++) begin
            in_data = DW'(100 + c);
            step();
            if (c >= 2) begin
                chk($sformatf("t3_crd[%0d]", c), b_crd, 1);
                chk($sformatf("t3_en[%0d]", c),  b_wr_en, 1);
            end
        end
        in_vld = 1'b0; fifo_rd_pop = 1'b0;

        // ---------------- Test 4: drain on A with two words in flight
        rst = 1'b1; step(); rst = 1'b0;
        in_vld = 1'b1; in_data = 32'h11; step();
        in_data = 32'h22; drain_req = 1'b1; step();
        drain_req = 1'b0; in_vld = 1'b0;
        chk("t4_rdy_drop", a_in_rdy, 0);
        chk("t4_first_data", a_wr_data, 32'h11);
        wr_cnt = a_wr_en ? 1 : 0; dn_cnt = 0; rdy_seen = 0; prev_done = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (prev_done) begin
                chk("t4_rdy_after_done", a_in_rdy, 1);
                rdy_seen++;
            end
            prev_done = a_done;
            if (a_wr_en) wr_cnt++;
            if (a_done) dn_cnt++;
        end
        chk("t4_writes", wr_cnt, 2);
        chk("t4_done_pulses", dn_cnt, 1);
        chk("t4_rdy_checked", rdy_seen, 1);
        chk("t4_last_data", a_wr_data, 32'h22);

        // ---------------- Test 4b: drain stalls on B with zero credits
        rst = 1'b1; step(); rst = 1'b0;
        fill_b(DW'(32'h200), acc, wr_cnt);
        drain_req = 1'b1; step(); drain_req = 1'b0;
        chk("t4b_rdy_drop", b_in_rdy, 0);
        dn_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (b_done) dn_cnt++;
        end
        chk("t4b_stalled_no_done", dn_cnt, 0);
        chk("t4b_stalled_buf", b_buf, 2);
        for (int c = 0; c < 12; c++) begin
            fifo_rd_pop = (c < 4);
            step();
            if (b_done) dn_cnt++;
        end
        fifo_rd_pop = 1'b0;
        chk("t4b_done_pulses", dn_cnt, 1);
        chk("t4b_buf_end", b_buf, 0);
        chk("t4b_rdy_end", b_in_rdy, 1);

        // ---------------- Test 5: extra return at full credit is saturated
        rst = 1'b1; step(); rst = 1'b0;
        fifo_rd_pop = 1'b1; step(); fifo_rd_pop = 1'b0;
        chk("t5_crd_a", a_crd, DA);
        chk("t5_crd_b", b_crd, DB);
        step();
        chk("t5_crd_a_hold", a_crd, DA);
`ifdef HMC_WR_CRD_CHECK_EN
        chk("t5_err_set", a_err, 1);
        repeat (3) step();
        chk("t5_err_sticky", a_err, 1);
        rst = 1'b1; step(); rst = 1'b0;
        chk("t5_err_cleared", a_err, 0);
`endif

        // ---------------- Test 6: reset mid-stream
        rst = 1'b1; step(); rst = 1'b0;
        fill_b(DW'(32'h300), acc, wr_cnt);
        chk("t6_pre_buf", b_buf, 2);
        chk("t6_pre_crd", b_crd, 0);
        in_vld = 1'b1; rst = 1'b1; step();
        chk("t6_en_a", a_wr_en, 0);
        chk("t6_en_b", b_wr_en, 0);
        chk("t6_buf_b", b_buf, 0);
        chk("t6_crd_b", b_crd, DB);
        chk("t6_crd_a", a_crd, DA);
        rst = 1'b0; in_vld = 1'b0; wr_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (a_wr_en) wr_cnt++;
            if (b_wr_en) wr_cnt++;
        end
        chk("t6_no_stale_writes", wr_cnt, 0);

        // ---------------- Random stimulus on B against a queue model
        rst = 1'b1; step(); rst = 1'b0;
        mq.delete();
        m_crd = DB; m_mode = 0; m_occ = 0; m_en = 1'b0; m_data = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            ret_pct     = ((cyc / 100) % 2 == 1) ? 80 : 30;
            in_vld      = ($urandom_range(0, 3) != 0);
            in_data     = $urandom;
            fifo_rd_pop = (m_occ > 0) && ($urandom_range(0, 99) < ret_pct);
            drain_req   = ($urandom_range(0, 39) == 0);

            m_rdy  = (m_mode == 0) && (mq.size() < 2);
            m_push = in_vld && m_rdy;
            m_pop  = (mq.size() > 0) && (m_crd > 0);
            m_ret  = fifo_rd_pop && (m_crd < DB);
            if (m_mode == 0)      m_nmode = drain_req ? 1 : 0;
            else if (m_mode == 1) m_nmode = (mq.size() == 0 && !m_en) ? 2 : 1;
            else                  m_nmode = 0;
            if (m_pop)  m_data = mq.pop_front();
            if (m_push) mq.push_back(in_data);
            m_mode = m_nmode;
            m_en   = m_pop;
            m_crd  = m_crd - int'(m_pop) + int'(m_ret);
            m_occ  = m_occ - int'(fifo_rd_pop) + int'(m_en);

            step();
            chk("rnd_rdy",  b_in_rdy,  (m_mode == 0) && (mq.size() < 2));
            chk("rnd_en",   b_wr_en,   m_en);
            chk("rnd_data", b_wr_data, m_data);
            chk("rnd_crd",  b_crd,     m_crd);
            chk("rnd_buf",  b_buf,     mq.size());
            chk("rnd_done", b_done,    (m_mode == 2));
        end
        in_vld = 1'b0; fifo_rd_pop = 1'b0; drain_req = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
